// File: rtl/prog_loader_pkg.sv
// Shared definitions for the writable program store and the core decoder:
// loader state encoding, the idle instruction and instruction field positions.
package prog_loader_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LOAD_HI = 2'd1,
    ST_LOAD_LO = 2'd2,
    ST_EXIT    = 2'd3
  } state_t;

  // No jump, no register write: safe to feed the core while it is held.
  localparam logic [7:0] NOP_INSTR = 8'h30;

  localparam int unsigned JUMP_HI = 7;
  localparam int unsigned JUMP_LO = 6;
  localparam int unsigned DEST_HI = 5;
  localparam int unsigned DEST_LO = 4;
  localparam int unsigned SEL_BIT = 3;
  localparam int unsigned IMM_HI  = 2;
  localparam int unsigned IMM_LO  = 0;

  function automatic logic [1:0] instr_jump(input logic [7:0] i);
    return i[JUMP_HI:JUMP_LO];
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Core-facing fetch bus: program counter in, instruction and core control out.
interface prog_loader_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
);
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] instr;
  logic              core_hold;
  logic              core_rst;

  // The core drives the PC and consumes the instruction and control lines.
  modport master (output pc, input instr, input core_hold, input core_rst);
  modport slave  (input pc, output instr, output core_hold, output core_rst);
endinterface

// File: rtl/prog_loader_sync_edge.sv
// Two-flop synchroniser for an asynchronous switch/button, with a one-cycle
// pulse on the rising edge of the synchronised level.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise
);
  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
endmodule

// File: rtl/prog_loader.sv
// Writable program store replacing the instruction ROM: combinational fetch in
// run mode, nibble-by-nibble entry from switches in load mode.
module prog_loader #(
  parameter int unsigned    ADDR_W    = 4,
  parameter int unsigned    DATA_W    = 8,
  parameter logic [DATA_W-1:0] NOP_INSTR = prog_loader_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              R,
  prog_loader_if.slave      core,
  input  logic              load_mode,
  input  logic [3:0]        nib_in,
  input  logic              nib_strobe,
  output logic [ADDR_W-1:0] load_addr,
  output logic              hi_pending,
  output logic              wrapped
);
  import prog_loader_pkg::*;

  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_t             state;
  logic [3:0]         hi;
  logic               hold_q;
  logic               rst_q;
  logic               load_lvl;
  logic               load_rise_unused;
  logic               strobe_ev;
  logic               strobe_lvl_unused;
  logic               wr_en;

  // Memory is deliberately outside the reset domain; R leaves the program intact.
  logic [DATA_W-1:0]  mem [DEPTH] = '{default: NOP_INSTR};

  sync_edge u_sync_load (
    .clk      (clk),
    .rst      (R),
    .async_in (load_mode),
    .level    (load_lvl),
    .rise     (load_rise_unused)
  );

  sync_edge u_sync_strobe (
    .clk      (clk),
    .rst      (R),
    .async_in (nib_strobe),
    .level    (strobe_lvl_unused),
    .rise     (strobe_ev)
  );

  assign wr_en = (state == ST_LOAD_LO) && strobe_ev && !R;

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[load_addr] <= {hi, nib_in};
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state      <= ST_RUN;
      load_addr  <= '0;
      hi         <= '0;
      hi_pending <= 1'b0;
      wrapped    <= 1'b0;
      hold_q     <= 1'b0;
      rst_q      <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (load_lvl) begin
            state     <= ST_LOAD_HI;
            load_addr <= '0;
            wrapped   <= 1'b0;
            hold_q    <= 1'b1;
          end
        end
        ST_LOAD_HI: begin
          if (strobe_ev) begin
            hi         <= nib_in;
            hi_pending <= 1'b1;
            state      <= ST_LOAD_LO;
          end else if (!load_lvl) begin
            state <= ST_EXIT;
            rst_q <= 1'b1;
          end
        end
        ST_LOAD_LO: begin
          // A strobe wins over a simultaneous load_mode drop; the drop is
          // seen again from LOAD_HI on the next edge.
          if (strobe_ev) begin
            load_addr  <= ADDR_W'(load_addr + 1'b1);
            hi_pending <= 1'b0;
            state      <= ST_LOAD_HI;
            if (&load_addr)
              wrapped <= 1'b1;
          end else if (!load_lvl) begin
            hi         <= '0;
            hi_pending <= 1'b0;
            state      <= ST_EXIT;
            rst_q      <= 1'b1;
          end
        end
        ST_EXIT: begin
          state  <= ST_RUN;
          rst_q  <= 1'b0;
          hold_q <= 1'b0;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  always_comb begin
    core.instr = NOP_INSTR;
    if (state == ST_RUN)
      core.instr = mem[core.pc];
  end

  assign core.core_hold = hold_q;
  assign core.core_rst  = rst_q;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: fetch, nibble loading, abort, wrap,
// strobe-hold, coincident strobe/drop and reset mid-load.
module tb_prog_loader;
  logic       clk = 1'b0;
  logic       R = 1'b1;
  logic       load_mode = 1'b0;
  logic [3:0] nib_in = 4'h0;
  logic       nib_strobe = 1'b0;
  logic [3:0] load_addr;
  logic       hi_pending;
  logic       wrapped;

  int tests = 0;
  int fails = 0;

  prog_loader_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  prog_loader #(.ADDR_W(4), .DATA_W(8), .NOP_INSTR(8'h30)) dut (
    .clk        (clk),
    .R          (R),
    .core       (bus.slave),
    .load_mode  (load_mode),
    .nib_in     (nib_in),
    .nib_strobe (nib_strobe),
    .load_addr  (load_addr),
    .hi_pending (hi_pending),
    .wrapped    (wrapped)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] nib);
    nib_in = nib;
    tick(3);
    nib_strobe = 1'b1;
    tick(4);
    nib_strobe = 1'b0;
    tick(4);
  endtask

  task automatic enter_byte(input logic [7:0] b);
    press(b[7:4]);
    press(b[3:0]);
  endtask

  task automatic enter_load();
    load_mode = 1'b1;
    tick(4);
  endtask

  // Drops load_mode and counts restart pulses over a bounded window.
  task automatic leave_load(output int pulses);
    pulses = 0;
    load_mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.core_rst === 1'b1) pulses++;
    end
  endtask

  task automatic test_reset();
    R = 1'b1;
    bus.pc = '0;
    tick(2);
    R = 1'b0;
    tick();
    tests++; if (bus.core_hold !== 1'b0) begin fails++; $display("FAIL reset_hold got=%b exp=0", bus.core_hold); end
    tests++; if (bus.core_rst !== 1'b0) begin fails++; $display("FAIL reset_rst got=%b exp=0", bus.core_rst); end
    tests++; if (load_addr !== 4'h0) begin fails++; $display("FAIL reset_addr got=%h exp=0", load_addr); end
    tests++; if (hi_pending !== 1'b0) begin fails++; $display("FAIL reset_hipend got=%b exp=0", hi_pending); end
    tests++; if (wrapped !== 1'b0) begin fails++; $display("FAIL reset_wrapped got=%b exp=0", wrapped); end
    for (int a = 0; a < 16; a++) begin
      bus.pc = 4'(a);
      #1;
      tests++; if (bus.instr !== 8'h30) begin fails++; $display("FAIL init_mem pc=%0d got=%h exp=30", a, bus.instr); end
    end
  endtask

  task automatic test_load_basic();
    int pulses;
    bus.pc = '0;
    enter_load();
    tests++; if (bus.core_hold !== 1'b1) begin fails++; $display("FAIL load_hold got=%b exp=1", bus.core_hold); end
    tests++; if (bus.instr !== 8'h30) begin fails++; $display("FAIL load_nop got=%h exp=30", bus.instr); end
    press(4'h3);
    tests++; if (hi_pending !== 1'b1) begin fails++; $display("FAIL hi_pending_set got=%b exp=1", hi_pending); end
    press(4'hA);
    tests++; if (hi_pending !== 1'b0) begin fails++; $display("FAIL hi_pending_clr got=%b exp=0", hi_pending); end
    enter_byte(8'h15);
    tests++; if (load_addr !== 4'h2) begin fails++; $display("FAIL basic_addr got=%h exp=2", load_addr); end
    leave_load(pulses);
    tests++; if (pulses !== 1) begin fails++; $display("FAIL basic_rst_pulses got=%0d exp=1", pulses); end
    tests++; if (bus.core_hold !== 1'b0) begin fails++; $display("FAIL basic_run_hold got=%b exp=0", bus.core_hold); end
    bus.pc = 4'h0; #1;
    tests++; if (bus.instr !== 8'h3A) begin fails++; $display("FAIL basic_mem0 got=%h exp=3a", bus.instr); end
    bus.pc = 4'h1; #1;
    tests++; if (bus.instr !== 8'h15) begin fails++; $display("FAIL basic_mem1 got=%h exp=15", bus.instr); end
    bus.pc = 4'h2; #1;
    tests++; if (bus.instr !== 8'h30) begin fails++; $display("FAIL basic_mem2 got=%h exp=30", bus.instr); end
  endtask

  task automatic test_abort();
    int pulses;
    enter_load();
    press(4'h7);
    tests++; if (hi_pending !== 1'b1) begin fails++; $display("FAIL abort_hipend got=%b exp=1", hi_pending); end
    leave_load(pulses);
    tests++; if (pulses !== 1) begin fails++; $display("FAIL abort_rst_pulses got=%0d exp=1", pulses); end
    tests++; if (hi_pending !== 1'b0) begin fails++; $display("FAIL abort_hipend_clr got=%b exp=0", hi_pending); end
    tests++; if (load_addr !== 4'h0) begin fails++; $display("FAIL abort_addr got=%h exp=0", load_addr); end
    bus.pc = 4'h0; #1;
    tests++; if (bus.instr !== 8'h3A) begin fails++; $display("FAIL abort_mem0 got=%h exp=3a", bus.instr); end
  endtask

  task automatic test_wrap();
    int pulses;
    enter_load();
    for (int b = 0; b < 15; b++) enter_byte(8'(b));
    tests++; if (wrapped !== 1'b0) begin fails++; $display("FAIL wrap_early got=%b exp=0", wrapped); end
    enter_byte(8'h0F);
    tests++; if (wrapped !== 1'b1) begin fails++; $display("FAIL wrap_set got=%b exp=1", wrapped); end
    tests++; if (load_addr !== 4'h0) begin fails++; $display("FAIL wrap_addr16 got=%h exp=0", load_addr); end
    enter_byte(8'h10);
    tests++; if (load_addr !== 4'h1) begin fails++; $display("FAIL wrap_addr17 got=%h exp=1", load_addr); end
    tests++; if (wrapped !== 1'b1) begin fails++; $display("FAIL wrap_sticky got=%b exp=1", wrapped); end
    leave_load(pulses);
    tests++; if (pulses !== 1) begin fails++; $display("FAIL wrap_rst_pulses got=%0d exp=1", pulses); end
    bus.pc = 4'h0; #1;
    tests++; if (bus.instr !== 8'h10) begin fails++; $display("FAIL wrap_mem0 got=%h exp=10", bus.instr); end
    bus.pc = 4'h1; #1;
    tests++; if (bus.instr !== 8'h01) begin fails++; $display("FAIL wrap_mem1 got=%h exp=01", bus.instr); end
    bus.pc = 4'hF; #1;
    tests++; if (bus.instr !== 8'h0F) begin fails++; $display("FAIL wrap_mem15 got=%h exp=0f", bus.instr); end
  endtask

  task automatic test_strobe_hold_and_coincident();
    int pulses;
    enter_load();
    tests++; if (wrapped !== 1'b0) begin fails++; $display("FAIL reenter_wrapped got=%b exp=0", wrapped); end
    nib_in = 4'h5;
    tick(3);
    nib_strobe = 1'b1;
    tick(50);
    tests++; if (hi_pending !== 1'b1) begin fails++; $display("FAIL hold_hipend got=%b exp=1", hi_pending); end
    tests++; if (load_addr !== 4'h0) begin fails++; $display("FAIL hold_addr got=%h exp=0", load_addr); end
    nib_strobe = 1'b0;
    tick(4);
    nib_in = 4'hC;
    tick(3);
    nib_strobe = 1'b1;
    load_mode = 1'b0;
    tick(3);
    tests++; if (load_addr !== 4'h1) begin fails++; $display("FAIL coinc_addr got=%h exp=1", load_addr); end
    tests++; if (bus.core_rst !== 1'b0) begin fails++; $display("FAIL coinc_rst_early got=%b exp=0", bus.core_rst); end
    tick();
    tests++; if (bus.core_rst !== 1'b1) begin fails++; $display("FAIL coinc_exit_rst got=%b exp=1", bus.core_rst); end
    tests++; if (bus.core_hold !== 1'b1) begin fails++; $display("FAIL coinc_exit_hold got=%b exp=1", bus.core_hold); end
    tick();
    tests++; if (bus.core_rst !== 1'b0) begin fails++; $display("FAIL coinc_run_rst got=%b exp=0", bus.core_rst); end
    tests++; if (bus.core_hold !== 1'b0) begin fails++; $display("FAIL coinc_run_hold got=%b exp=0", bus.core_hold); end
    nib_strobe = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.core_rst === 1'b1) pulses++;
    end
    tests++; if (pulses !== 0) begin fails++; $display("FAIL coinc_extra_pulses got=%0d exp=0", pulses); end
    bus.pc = 4'h0; #1;
    tests++; if (bus.instr !== 8'h5C) begin fails++; $display("FAIL coinc_mem0 got=%h exp=5c", bus.instr); end
  endtask

  task automatic test_reset_midload();
    int pulses;
    enter_load();
    enter_byte(8'hA1);
    enter_byte(8'hB2);
    press(4'h4);
    tests++; if (hi_pending !== 1'b1) begin fails++; $display("FAIL midrst_prehipend got=%b exp=1", hi_pending); end
    load_mode = 1'b0;
    R = 1'b1;
    tick();
    R = 1'b0;
    tests++; if (bus.core_rst !== 1'b0) begin fails++; $display("FAIL midrst_rst got=%b exp=0", bus.core_rst); end
    tests++; if (bus.core_hold !== 1'b0) begin fails++; $display("FAIL midrst_hold got=%b exp=0", bus.core_hold); end
    tests++; if (load_addr !== 4'h0) begin fails++; $display("FAIL midrst_addr got=%h exp=0", load_addr); end
    tests++; if (hi_pending !== 1'b0) begin fails++; $display("FAIL midrst_hipend got=%b exp=0", hi_pending); end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.core_rst === 1'b1) pulses++;
    end
    tests++; if (pulses !== 0) begin fails++; $display("FAIL midrst_pulses got=%0d exp=0", pulses); end
    bus.pc = 4'h0; #1;
    tests++; if (bus.instr !== 8'hA1) begin fails++; $display("FAIL midrst_mem0 got=%h exp=a1", bus.instr); end
    bus.pc = 4'h1; #1;
    tests++; if (bus.instr !== 8'hB2) begin fails++; $display("FAIL midrst_mem1 got=%h exp=b2", bus.instr); end
    bus.pc = 4'h2; #1;
    tests++; if (bus.instr !== 8'h0F && bus.instr !== 8'h02) begin fails++; $display("FAIL midrst_mem2 got=%h exp=02", bus.instr); end
  endtask

  initial begin
    bus.pc = '0;
    test_reset();
    test_load_basic();
    test_abort();
    test_wrap();
    test_strobe_hold_and_coincident();
    test_reset_midload();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writable program store that sits directly upstream of the processor core and replaces the fixed instruction ROM.
- Run mode: returns the 8-bit instruction at the program counter address, combinationally, exactly like the ROM it replaces.
- Load mode: the operator enters the program from board switches one nibble at a time. The core is held and given a restart pulse on exit so execution begins at address 0.

Parameters:
- ADDR_W, 4, program address width; depth = 2**ADDR_W words.
- DATA_W, 8, instruction width; fixed at 8 by the instruction format (jump[7:6], dest[5:4], sel[3], imm[2:0]).
- NOP_INSTR, 8'h30, instruction presented to the core while not in run mode (no jump, no register write).

Ports:
- clk  input  1  system clock (board key clock).
- R  input  1  synchronous active-high reset.
- pc  input  ADDR_W  program counter from the counter stage.
- load_mode  input  1  async switch level; 1 = load mode requested.
- nib_in  input  4  nibble data switches; must be stable for at least 3 cycles before nib_strobe rises.
- nib_strobe  input  1  async active-high enter button.
- instr  output  DATA_W  instruction to the core's mux, decoder and counter.
- core_hold  output  1  1 = core must not update registers or PC.
- core_rst  output  1  one-cycle restart pulse to the core, ORed with R at the top.
- load_addr  output  ADDR_W  next address to be written (drives the display while loading).
- hi_pending  output  1  1 = high nibble latched, low nibble awaited.
- wrapped  output  1  sticky; set when load_addr wraps past the last word during the current load session.

Behaviour:
- Sync: load_mode and nib_strobe each pass through a 2-flop synchroniser. A strobe event is a rising edge of the synchronised strobe (third flop compare), one-cycle pulse. nib_in is sampled in the cycle the event pulse is high.
- Reset (R=1 at clk edge) sets:
  - state=RUN, load_addr=0, hi register=0, hi_pending=0, wrapped=0, core_hold=0, core_rst=0.
  - Synchroniser flops to 0.
  - Memory contents are NOT affected by R. Configuration-time contents = NOP_INSTR in every word.
- States RUN, LOAD_HI, LOAD_LO, EXIT.
- RUN:
  - instr = mem[pc], combinational, zero latency; core_hold=0.
  - Synchronised load_mode=1 -> LOAD_HI, with load_addr=0 and wrapped=0.
- LOAD_HI:
  - instr=NOP_INSTR, core_hold=1.
  - Strobe event -> hi<=nib_in, hi_pending=1, -> LOAD_LO.
  - Else if load_mode=0 -> EXIT.
- LOAD_LO:
  - instr=NOP_INSTR, core_hold=1.
  - Strobe event -> mem[load_addr]<={hi,nib_in}, load_addr<=load_addr+1 mod 2**ADDR_W, hi_pending=0, -> LOAD_HI.
  - If load_addr was all-ones at that write -> wrapped<=1.
  - Else if load_mode=0 -> discard hi, hi_pending=0, -> EXIT.
- EXIT:
  - core_hold=1, core_rst=1 for exactly this one cycle, instr=NOP_INSTR, -> RUN unconditionally.
  - The first RUN cycle therefore sees pc=0 from the restarted core.
- Priority in the same cycle: R > strobe event > load_mode drop. A drop coincident with a strobe is acted on in the following cycle.
- Re-entering load_mode while in EXIT is ignored until RUN; RUN then re-evaluates it on the next edge.
- Each physical press produces exactly one write; holding the strobe high produces nothing further.
- Memory write port is used only in LOAD_LO. There is no read/write collision because instr is forced to NOP while loading.
- Reset mid-load: immediate return to RUN, partial nibble lost, already-written words kept, no core_rst pulse (R itself resets the core).

Decomposition:
- Shared package: state encoding (RUN/LOAD_HI/LOAD_LO/EXIT), NOP_INSTR, and instruction field position constants used by the core decoder.
- One natural sub-module: sync_edge (2-flop synchroniser plus rising-edge pulse), instantiated twice; the load_mode instance uses only the level output.
- Memory is an inferred register array in this module.

Test Plan:
- Reset then RUN with pc=0..15 -> instr=8'h30 at every address; core_hold=0, core_rst=0.
- load_mode=1; enter nibbles 3,A then 1,5 -> mem[0]=8'h3A, mem[1]=8'h15, load_addr=2. Drop load_mode -> one core_rst pulse, then RUN; pc=0 gives 8'h3A, pc=1 gives 8'h15.
- Enter high nibble 7, drop load_mode before the low nibble -> no write, mem[load_addr] unchanged, hi_pending returns to 0, core_rst pulses once.
- 17 full bytes 8'h00..8'h10 -> wrapped=1 after the 16th; mem[0]=8'h10 overwritten; load_addr=1.
- Strobe held high for 50 cycles -> exactly one nibble accepted; strobe rise coincident with load_mode drop in LOAD_LO -> write occurs, EXIT next cycle.
- Assert R while in LOAD_LO after 2 writes -> state RUN, load_addr=0, core_rst stays 0, mem[0..1] retained.
